// File: rtl/ps2_frame_receiver_if.sv
// Purpose: groups the PS/2 pin inputs and the decoded scancode outputs of the frame receiver.
// Latency: none (wiring only).
// Backpressure: none; received is a stretched strobe and error a one-cycle pulse, with no ready path.
// Signals:
//   psclk, psdata : raw asynchronous PS/2 pins (driven by the master side)
//   value         : last good scancode byte
//   received      : stretched strobe, high for RX_HOLD cycles after each good frame
//   error         : one-cycle pulse on a bad or aborted frame
//   busy          : high while a frame is being collected or checked
interface ps2_frame_receiver_if;
    logic       psclk;
    logic       psdata;
    logic [7:0] value;
    logic       received;
    logic       error;
    logic       busy;

    modport master (
        output psclk,
        output psdata,
        input  value,
        input  received,
        input  error,
        input  busy
    );

    modport slave (
        input  psclk,
        input  psdata,
        output value,
        output received,
        output error,
        output busy
    );
endinterface

// File: rtl/ps2_frame_receiver.sv
// Purpose: PS/2 device-to-host frame receiver; sync + de-glitch pins, deserialise 11-bit frames, check start/odd parity/stop.
// Latency: raw psclk fall to sample event 2+FILTER_LEN cycles; stop-bit sample event N -> value/received or error at N+2.
// Backpressure: none; received is held for RX_HOLD cycles so slow divided-clock logic cannot miss it.
// Ports:
//   clkCPU : system clock, the only clock in the block
//   reset  : asynchronous active-high reset; discards any frame in progress
//   bus    : slave side of ps2_frame_receiver_if (psclk/psdata in; value/received/error/busy out)
module ps2_frame_receiver #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int RX_HOLD        = 6
) (
    input  logic                  clkCPU,
    input  logic                  reset,
    ps2_frame_receiver_if.slave   bus
);

    localparam logic [3:0]  FILT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [3:0]  HOLD_LOAD = 4'(RX_HOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t      state, state_nxt;

    logic [1:0]  psclk_sync, psdata_sync;
    logic        psclk_s, psdata_s;
    logic [3:0]  filt_cnt;
    logic        filt_clk, filt_clk_d;
    logic        sample_evt;

    logic [9:0]  shreg;
    logic [3:0]  bit_cnt;
    logic [15:0] tmo_cnt;
    logic [3:0]  hold_cnt;
    logic [7:0]  value_q;
    logic        error_q;
    logic        frame_ok;

    logic        start_frame, shift_en, tmo_inc, load_good, err_nxt;

    // Two-flop synchronisers; idle bus level is high, so they reset to 1.
    always_ff @(posedge clkCPU or posedge reset) begin
        if (reset) begin
            psclk_sync  <= 2'b11;
            psdata_sync <= 2'b11;
        end else begin
            psclk_sync  <= {psclk_sync[0], bus.psclk};
            psdata_sync <= {psdata_sync[0], bus.psdata};
        end
    end

    assign psclk_s  = psclk_sync[1];
    assign psdata_s = psdata_sync[1];

    // Glitch filter: the filtered clock follows the synchronised pin only after
    // FILTER_LEN consecutive disagreeing samples; any agreeing sample restarts the run.
    always_ff @(posedge clkCPU or posedge reset) begin
        if (reset) begin
            filt_cnt   <= '0;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            filt_clk_d <= filt_clk;
            if (psclk_s != filt_clk) begin
                if (filt_cnt == FILT_LAST) begin
                    filt_clk <= psclk_s;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 4'd1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // Filtered falling edge; data is taken from the synchroniser in this same cycle.
    assign sample_evt = filt_clk_d & ~filt_clk;

    // After ten LSB-first shifts: [7:0] data, [8] parity, [9] stop.
    assign frame_ok = (^shreg[8:0]) & shreg[9];

    always_ff @(posedge clkCPU or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        tmo_inc     = 1'b0;
        load_good   = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                // A data-1 "start" edge is line noise or a stray clock; ignore it silently.
                if (sample_evt && !psdata_s) begin
                    start_frame = 1'b1;
                    state_nxt   = RECV;
                end
            end
            RECV: begin
                // A sample arriving in the same cycle as the timeout still counts.
                if (sample_evt) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 4'd9) begin
                        state_nxt = CHECK;
                    end
                end else if (tmo_cnt == TMO_LIMIT) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
                if (frame_ok) begin
                    load_good = 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clkCPU or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            tmo_cnt  <= '0;
            hold_cnt <= '0;
            value_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            error_q <= err_nxt;

            if (start_frame) begin
                bit_cnt <= '0;
                tmo_cnt <= '0;
            end else if (shift_en) begin
                shreg   <= {psdata_s, shreg[9:1]};
                bit_cnt <= bit_cnt + 4'd1;
                tmo_cnt <= '0;
            end else if (tmo_inc) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end

            if (load_good) begin
                value_q <= shreg[7:0];
            end

            // Hold counter runs on its own; a new good frame simply restarts it.
            if (load_good) begin
                hold_cnt <= HOLD_LOAD;
            end else if (hold_cnt != 4'd0) begin
                hold_cnt <= hold_cnt - 4'd1;
            end
        end
    end

    assign bus.value    = value_q;
    assign bus.received = (hold_cnt != 4'd0);
    assign bus.error    = error_q;
    assign bus.busy     = (state != IDLE);

endmodule
